// File: rtl/hazard_ctrl_pkg.sv
// Shared types and default sizing for the pipeline hazard controller.
// Pure declarations: no logic, no latency, no flow control.
package hazard_ctrl_pkg;

    localparam int HZ_REG_W      = 5;
    localparam int HZ_MD_TIMEOUT = 64;
    localparam int HZ_CNT_W      = 7;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_MD_BUSY = 1'b1
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller side.
// Outputs are combinational from state and inputs, so no handshake latency here.
interface hazard_ctrl_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 7
);
    logic [REG_W-1:0] IFID_rs_i;
    logic [REG_W-1:0] IFID_rt_i;
    logic [REG_W-1:0] IDEX_rt_i;
    logic             IDEX_memread_i;
    logic             IDEX_muldiv_i;
    logic             jump_i;
    logic             branch_taken_i;
    logic             muldiv_done_i;

    logic             pc_write_o;
    logic             IFID_stall_o;
    logic             IDEX_stall_o;
    logic             IFID_flush_o;
    logic             IDEX_flush_o;
    logic             EXMEM_flush_o;
    logic             muldiv_go_o;
    logic             muldiv_abort_o;
    logic             err_o;
    logic             state_o;
    logic [CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_memread_i, IDEX_muldiv_i,
               jump_i, branch_taken_i, muldiv_done_i,
        output pc_write_o, IFID_stall_o, IDEX_stall_o, IFID_flush_o, IDEX_flush_o,
               EXMEM_flush_o, muldiv_go_o, muldiv_abort_o, err_o, state_o, stall_cnt_o
    );

    modport master (
        output IFID_rs_i, IFID_rt_i, IDEX_rt_i, IDEX_memread_i, IDEX_muldiv_i,
               jump_i, branch_taken_i, muldiv_done_i,
        input  pc_write_o, IFID_stall_o, IDEX_stall_o, IFID_flush_o, IDEX_flush_o,
               EXMEM_flush_o, muldiv_go_o, muldiv_abort_o, err_o, state_o, stall_cnt_o
    );
endinterface

// File: rtl/hazard_ldu_cmp.sv
// Load-use detector: load in EX writing a non-zero register read by the ID instruction.
// Purely combinational, zero latency, no backpressure.
module hazard_ldu_cmp
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W = HZ_REG_W
) (
    input  logic             memread_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             hazard_o
);

    assign hazard_o = memread_i && (ex_rt_i != '0) &&
                      ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/flush controller: load-use, branch/jump squash, mul/div occupancy with watchdog.
// Controls are same-cycle (Mealy); MD_BUSY holds the front end until done or timeout.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W      = HZ_REG_W,
    parameter int MD_TIMEOUT = HZ_MD_TIMEOUT,
    parameter int CNT_W      = HZ_CNT_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    hazard_ctrl_if.slave  hz
);

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(MD_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             ldu_hz;
    logic             tmo_hit;

    logic pc_write, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_flush;
    logic md_go, md_abort;

    hazard_ldu_cmp #(.REG_W(REG_W)) u_ldu_cmp (
        .memread_i (hz.IDEX_memread_i),
        .ex_rt_i   (hz.IDEX_rt_i),
        .id_rs_i   (hz.IFID_rs_i),
        .id_rt_i   (hz.IFID_rt_i),
        .hazard_o  (ldu_hz)
    );

    assign tmo_hit = (cnt_q == TMO_CNT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // A taken branch outranks a mul/div in EX: the mul/div is squashed, never started.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (!hz.branch_taken_i && hz.IDEX_muldiv_i) begin
                    state_d = ST_MD_BUSY;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_MD_BUSY: begin
                if (hz.muldiv_done_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        md_go       = 1'b0;
        md_abort    = 1'b0;
        if (!rst_i) begin
            pc_write = 1'b0;
        end else if (state_q == ST_RUN) begin
            if (hz.branch_taken_i) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (hz.IDEX_muldiv_i) begin
                md_go       = 1'b1;
                pc_write    = 1'b0;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
            end else if (ldu_hz) begin
                pc_write    = 1'b0;
                ifid_stall  = 1'b1;
                idex_flush  = 1'b1;
            end else if (hz.jump_i) begin
                ifid_flush  = 1'b1;
            end
        end else begin
            // Done releases everything so the result advances into EX/MEM this edge.
            if (hz.muldiv_done_i) begin
                pc_write    = 1'b1;
            end else if (tmo_hit) begin
                md_abort    = 1'b1;
                idex_flush  = 1'b1;
                ifid_stall  = 1'b1;
                pc_write    = 1'b0;
            end else begin
                pc_write    = 1'b0;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_flush = 1'b1;
            end
        end
    end

    assign hz.pc_write_o     = pc_write;
    assign hz.IFID_stall_o   = ifid_stall;
    assign hz.IDEX_stall_o   = idex_stall;
    assign hz.IFID_flush_o   = ifid_flush;
    assign hz.IDEX_flush_o   = idex_flush;
    assign hz.EXMEM_flush_o  = exmem_flush;
    assign hz.muldiv_go_o    = md_go;
    assign hz.muldiv_abort_o = md_abort;
    assign hz.err_o          = err_q;
    assign hz.state_o        = state_q;
    assign hz.stall_cnt_o    = cnt_q;

endmodule
